airi5c_hasti_to_sram_bridge: RTL and testbench

HASTI (AHB-lite) slave that terminates bus transfers from the core or interconnect into a single-port synchronous SRAM. The SRAM has a 1-cycle read latency. Reads are zero-wait. Writes are absorbed by a one-entry write buffer with byte-merge read forwarding, so back-to-back transfers run at full rate except for one defined collision case.

---
 rtl/airi5c_hasti_to_sram_bridge_if.sv | 48 ++++
 rtl/airi5c_hasti_to_sram_bridge.sv | 183 ++++++++++++++++++
 tb/tb_airi5c_hasti_to_sram_bridge.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/airi5c_hasti_to_sram_bridge_if.sv
// HASTI (AHB-lite) slave-side signal bundle for the SRAM bridge.
// Also supplies default HASTI width macros when no HASTI constants header is present.
`ifndef HASTI_ADDR_WIDTH
`define HASTI_ADDR_WIDTH 32
`endif
`ifndef HASTI_BUS_WIDTH
`define HASTI_BUS_WIDTH 32
`endif
`ifndef HASTI_SIZE_WIDTH
`define HASTI_SIZE_WIDTH 3
`endif
`ifndef HASTI_BURST_WIDTH
`define HASTI_BURST_WIDTH 3
`endif
`ifndef HASTI_PROT_WIDTH
`define HASTI_PROT_WIDTH 4
`endif
`ifndef HASTI_TRANS_WIDTH
`define HASTI_TRANS_WIDTH 2
`endif
`ifndef HASTI_RESP_WIDTH
`define HASTI_RESP_WIDTH 1
`endif

interface airi5c_hasti_to_sram_bridge_if;
    logic                           hsel;
    logic [`HASTI_ADDR_WIDTH-1:0]   haddr;
    logic                           hwrite;
    logic [`HASTI_SIZE_WIDTH-1:0]   hsize;
    logic [`HASTI_BURST_WIDTH-1:0]  hburst;
    logic                           hmastlock;
    logic [`HASTI_PROT_WIDTH-1:0]   hprot;
    logic [`HASTI_TRANS_WIDTH-1:0]  htrans;
    logic [`HASTI_BUS_WIDTH-1:0]    hwdata;
    logic [`HASTI_BUS_WIDTH-1:0]    hrdata;
    logic                           hready;
    logic [`HASTI_RESP_WIDTH-1:0]   hresp;

    modport master (
        output hsel, haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  hsel, haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/airi5c_hasti_to_sram_bridge.sv
// HASTI slave into a 1-cycle-latency single-port SRAM: zero-wait reads, one-entry write buffer
// with byte-merge forwarding. Optional alignment checking: AIRI5C_HASTI_SRAM_ALIGN_CHECK_EN.
module airi5c_hasti_to_sram_bridge #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                         clk,
    input  logic                         nreset,
    airi5c_hasti_to_sram_bridge_if.slave bus,
    output logic                         sram_en,
    output logic                         sram_we,
    output logic [ADDR_WIDTH-1:0]        sram_addr,
    output logic [3:0]                   sram_be,
    output logic [31:0]                  sram_wdata,
    input  logic [31:0]                  sram_rdata
);

    localparam logic [`HASTI_RESP_WIDTH-1:0] HRESP_OKAY  = '0;
    localparam logic [`HASTI_RESP_WIDTH-1:0] HRESP_ERROR = `HASTI_RESP_WIDTH'(1);

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_READ,
        PH_WRITE,
        PH_ERR1,
        PH_ERR2
    } phase_e;

    phase_e                phase_q, phase_d;
    logic [ADDR_WIDTH-1:0] dp_addr_q, dp_addr_d;
    logic [3:0]            dp_be_q, dp_be_d;

    logic                  wb_valid_q, wb_valid_d;
    logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
    logic [3:0]            wb_be_q, wb_be_d;
    logic [31:0]           wb_data_q, wb_data_d;

    logic [ADDR_WIDTH-1:0] ap_word;
    logic [3:0]            ap_be;
    logic                  ap_req;
    logic                  ap_err;
    logic                  dp_read;
    logic                  dp_write;
    logic                  collision;
    logic                  ready;
    logic                  accept;
    logic                  rd_issue;
    logic                  wr_capture;
    logic                  fwd_hit;
    logic [31:0]           merged;
    logic                  unused_inputs;

    assign unused_inputs = ^{bus.hburst, bus.hmastlock, bus.hprot, bus.htrans[0],
                             bus.haddr[`HASTI_ADDR_WIDTH-1:ADDR_WIDTH+2]};

    // Address-phase decode
    always_comb begin
        ap_word = bus.haddr[ADDR_WIDTH+1:2];
        ap_req  = bus.hsel & bus.htrans[1];
        case (bus.hsize)
            3'd0:    ap_be = 4'b0001 << bus.haddr[1:0];
            3'd1:    ap_be = bus.haddr[1] ? 4'b1100 : 4'b0011;
            default: ap_be = 4'b1111;
        endcase
`ifdef AIRI5C_HASTI_SRAM_ALIGN_CHECK_EN
        ap_err = ((bus.hsize == 3'd1) & bus.haddr[0])
               | ((bus.hsize == 3'd2) & (|bus.haddr[1:0]))
               | (bus.hsize > 3'd2);
`else
        ap_err = 1'b0;
`endif
    end

    // A read address phase needs the port in the same cycle a buffered write must make room
    // for the write in its data phase; the buffer wins for one cycle and the read waits.
    always_comb begin
        dp_read    = (phase_q == PH_READ);
        dp_write   = (phase_q == PH_WRITE);
        collision  = wb_valid_q & dp_write & ap_req & ~bus.hwrite & ~ap_err;
        ready      = ~collision & (phase_q != PH_ERR1);
        accept     = ap_req & ready;
        rd_issue   = accept & ~bus.hwrite & ~ap_err;
        wr_capture = dp_write & ready;
    end

    // Data-phase context and response sequencing
    always_comb begin
        phase_d   = phase_q;
        dp_addr_d = dp_addr_q;
        dp_be_d   = dp_be_q;
        if (phase_q == PH_ERR1) begin
            phase_d = PH_ERR2;
        end else if (ready) begin
            if (accept) begin
                if (ap_err) begin
                    phase_d = PH_ERR1;
                end else if (bus.hwrite) begin
                    phase_d = PH_WRITE;
                end else begin
                    phase_d = PH_READ;
                end
                dp_addr_d = ap_word;
                dp_be_d   = ap_be;
            end else begin
                phase_d = PH_IDLE;
            end
        end
    end

    // Write buffer: a capture replaces the entry even while it is being drained
    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_addr_d  = wb_addr_q;
        wb_be_d    = wb_be_q;
        wb_data_d  = wb_data_q;
        if (wr_capture) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = dp_addr_q;
            wb_be_d    = dp_be_q;
            wb_data_d  = bus.hwdata;
        end else if (wb_valid_q & ~rd_issue) begin
            wb_valid_d = 1'b0;
        end
    end

    // SRAM port: read address phase has priority over the drain
    always_comb begin
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_be    = '0;
        sram_wdata = '0;
        if (rd_issue) begin
            sram_en   = 1'b1;
            sram_addr = ap_word;
            sram_be   = ap_be;
        end else if (wb_valid_q) begin
            sram_en    = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = wb_addr_q;
            sram_be    = wb_be_q;
            sram_wdata = wb_data_q;
        end
    end

    // Read data with byte-lane forwarding from the buffered write
    always_comb begin
        fwd_hit = wb_valid_q & (wb_addr_q == dp_addr_q);
        merged  = sram_rdata;
        for (int unsigned i = 0; i < 4; i++) begin
            if (fwd_hit & wb_be_q[i]) begin
                merged[8*i +: 8] = wb_data_q[8*i +: 8];
            end
        end
        bus.hrdata = dp_read ? merged : '0;
        bus.hready = ready;
`ifdef AIRI5C_HASTI_SRAM_ALIGN_CHECK_EN
        bus.hresp  = ((phase_q == PH_ERR1) | (phase_q == PH_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
`else
        bus.hresp  = HRESP_OKAY;
`endif
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            phase_q    <= PH_IDLE;
            dp_addr_q  <= '0;
            dp_be_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_be_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            phase_q    <= phase_d;
            dp_addr_q  <= dp_addr_d;
            dp_be_q    <= dp_be_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_be_q    <= wb_be_d;
            wb_data_q  <= wb_data_d;
        end
    end

endmodule

// File: tb/tb_airi5c_hasti_to_sram_bridge.sv
// Self-checking bench for airi5c_hasti_to_sram_bridge: directed scenarios plus randomized
// transfer streams checked against a word-array memory model and a wait-state rule.
`timescale 1ns/1ps
module tb_airi5c_hasti_to_sram_bridge;

    localparam int AW = 8;
    localparam int NW = 1 << AW;

    logic          clk = 1'b0;
    logic          nreset;
    logic          sram_en, sram_we;
    logic [AW-1:0] sram_addr;
    logic [3:0]    sram_be;
    logic [31:0]   sram_wdata, sram_rdata;

    always #5 clk = ~clk;

    airi5c_hasti_to_sram_bridge_if bus();

    airi5c_hasti_to_sram_bridge #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .bus        (bus),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_be    (sram_be),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // Synchronous SRAM, one cycle read latency
    logic [31:0] sram_mem [NW];
    logic [31:0] rdata_q;
    assign sram_rdata = rdata_q;
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] = sram_wdata[8*b +: 8];
            end else begin
                rdata_q <= sram_mem[sram_addr];
            end
        end
    end

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
        int          gap;
    } xfer_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [31:0]   data;
        int            cyc;
    } wev_t;

    logic [31:0] ref_mem [NW];
    xfer_t       xf [64];
    int          n_xf;
    logic [31:0] obs_rdata [64];
    int          obs_wait [64];
    int          obs_cycles, seq_done, idle_waits, bad_hrdata, err_cycles, stall_cyc;
    wev_t        wlog [$];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [3:0] exp_be(input logic [2:0] size, input logic [1:0] off);
        if (size == 3'd0) return 4'(1 << off);
        if (size == 3'd1) return off[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    task automatic model_apply();
        logic [3:0] be;
        for (int k = 0; k < n_xf; k++) begin
            if (xf[k].wr) begin
                be = exp_be(xf[k].size, xf[k].addr[1:0]);
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[xf[k].addr[AW+1:2]][8*b +: 8] = xf[k].data[8*b +: 8];
            end
        end
    endtask

    task automatic bus_idle();
        bus.hsel = 1'b0; bus.htrans = 2'b00; bus.haddr = '0; bus.hwrite = 1'b0;
        bus.hsize = 3'd0; bus.hwdata = '0; bus.hburst = '0; bus.hmastlock = 1'b0; bus.hprot = '0;
    endtask

    task automatic set_xf(input int k, input bit wr, input logic [31:0] addr,
                          input logic [2:0] size, input logic [31:0] data, input int gap);
        xf[k].wr = wr; xf[k].addr = addr; xf[k].size = size; xf[k].data = data; xf[k].gap = gap;
    endtask

    // Pipelined master: presents xf[] in order and records what it observes
    task automatic run_seq(input int drain_cycles);
        int  ap, dp, gap_left, cyc;
        bit  present;
        ap = 0; dp = -1; cyc = 0; seq_done = 0;
        idle_waits = 0; bad_hrdata = 0; err_cycles = 0; stall_cyc = -1;
        wlog.delete();
        for (int k = 0; k < n_xf; k++) begin obs_wait[k] = 0; obs_rdata[k] = '0; end
        gap_left = (n_xf > 0) ? xf[0].gap : 0;
        while (seq_done < n_xf && cyc < 2000) begin
            present = (ap < n_xf) && (gap_left == 0);
            bus_idle();
            if (present) begin
                bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = xf[ap].addr;
                bus.hwrite = xf[ap].wr; bus.hsize = xf[ap].size;
            end
            if (dp >= 0 && xf[dp].wr) bus.hwdata = xf[dp].data;
            @(negedge clk);
            cyc++;
            if (sram_en && sram_we) wlog.push_back('{sram_addr, sram_be, sram_wdata, cyc});
            if (bus.hresp !== 1'b0) err_cycles++;
            if (!(dp >= 0 && !xf[dp].wr) && bus.hrdata !== 32'h0) bad_hrdata++;
            if (bus.hready) begin
                if (dp >= 0) begin
                    if (!xf[dp].wr) obs_rdata[dp] = bus.hrdata;
                    seq_done++;
                end
                if (present) begin
                    dp = ap; ap++;
                    gap_left = (ap < n_xf) ? xf[ap].gap : 0;
                end else begin
                    dp = -1;
                    if (gap_left > 0) gap_left--;
                end
            end else begin
                if (present) obs_wait[ap]++; else idle_waits++;
                stall_cyc = cyc;
            end
            @(posedge clk); #1;
        end
        obs_cycles = cyc;
        bus_idle();
        for (int i = 0; i < drain_cycles; i++) begin
            @(negedge clk);
            cyc++;
            if (sram_en && sram_we) wlog.push_back('{sram_addr, sram_be, sram_wdata, cyc});
            if (bus.hrdata !== 32'h0) bad_hrdata++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        bus_idle();
        nreset = 1'b0;
        #3;
        checks++;
        if ({bus.hready, bus.hresp} !== 2'b10) begin
            errors++; $display("FAIL reset_hready_hresp: got %b required 10", {bus.hready, bus.hresp});
        end
        checks++;
        if (bus.hrdata !== 32'h0) begin
            errors++; $display("FAIL reset_hrdata: got %h required 0", bus.hrdata);
        end
        checks++;
        if ({sram_en, sram_we, sram_be, sram_addr, sram_wdata} !== '0) begin
            errors++; $display("FAIL reset_sram: en=%b we=%b be=%b addr=%h wdata=%h required all 0",
                               sram_en, sram_we, sram_be, sram_addr, sram_wdata);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); nreset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_word_write_read();
        n_xf = 2;
        set_xf(0, 1, 32'h10, 3'd2, 32'hDEADBEEF, 0);
        set_xf(1, 0, 32'h10, 3'd2, 32'h0, 1);
        run_seq(3);
        checks++;
        if (seq_done !== 2) begin errors++; $display("FAIL ww_done: got %0d required 2", seq_done); end
        checks++;
        if (obs_rdata[1] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL ww_rdata: got %h required deadbeef", obs_rdata[1]);
        end
        checks++;
        if (obs_wait[0] + obs_wait[1] + idle_waits !== 0) begin
            errors++; $display("FAIL ww_waits: got %0d required 0", obs_wait[0] + obs_wait[1] + idle_waits);
        end
        checks++;
        if (wlog.size() != 1 || wlog[0].addr !== 8'h04 || wlog[0].be !== 4'hF || wlog[0].data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL ww_sram_write: got %0d writes (first addr %h be %b) required 1 write addr 04 be 1111",
                               wlog.size(), (wlog.size() > 0) ? wlog[0].addr : 8'h0, (wlog.size() > 0) ? wlog[0].be : 4'h0);
        end
        model_apply();
    endtask

    task automatic test_forward();
        sram_mem[8] = 32'h11223344; ref_mem[8] = 32'h11223344;
        n_xf = 2;
        set_xf(0, 1, 32'h21, 3'd0, 32'h0000AA00, 0);
        set_xf(1, 0, 32'h20, 3'd2, 32'h0, 0);
        run_seq(3);
        checks++;
        if (obs_rdata[1] !== 32'h1122AA44) begin
            errors++; $display("FAIL fwd_rdata: got %h required 1122aa44", obs_rdata[1]);
        end
        checks++;
        if (obs_wait[1] + idle_waits !== 0) begin
            errors++; $display("FAIL fwd_waits: got %0d required 0", obs_wait[1] + idle_waits);
        end
        checks++;
        if (sram_mem[8] !== 32'h1122AA44) begin
            errors++; $display("FAIL fwd_sram_word: got %h required 1122aa44", sram_mem[8]);
        end
        model_apply();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_rd;
        int          first_addr, first_cyc;
        exp_rd = ref_mem[2];
        n_xf = 3;
        set_xf(0, 1, 32'h00, 3'd2, 32'hA0A0A0A0, 0);
        set_xf(1, 1, 32'h04, 3'd2, 32'hB1B1B1B1, 0);
        set_xf(2, 0, 32'h08, 3'd2, 32'h0, 0);
        run_seq(3);
        checks++;
        if (obs_wait[2] !== 1 || obs_wait[0] + obs_wait[1] + idle_waits !== 0) begin
            errors++; $display("FAIL b2b_waits: got %0d/%0d/%0d idle %0d required 0/0/1 idle 0",
                               obs_wait[0], obs_wait[1], obs_wait[2], idle_waits);
        end
        checks++;
        if (obs_cycles !== 5) begin errors++; $display("FAIL b2b_cycles: got %0d required 5", obs_cycles); end
        first_addr = (wlog.size() > 0) ? int'(wlog[0].addr) : -1;
        first_cyc  = (wlog.size() > 0) ? wlog[0].cyc : -1;
        checks++;
        if (first_addr !== 0 || first_cyc !== stall_cyc || stall_cyc !== 3) begin
            errors++; $display("FAIL b2b_drain: got addr %0d at cycle %0d (stall cycle %0d) required addr 0 at cycle 3",
                               first_addr, first_cyc, stall_cyc);
        end
        checks++;
        if (obs_rdata[2] !== exp_rd) begin
            errors++; $display("FAIL b2b_rdata: got %h required %h", obs_rdata[2], exp_rd);
        end
        model_apply();
    endtask

    task automatic test_halfword();
        n_xf = 1;
        set_xf(0, 1, 32'h32, 3'd1, 32'hBEEF0000, 0);
        run_seq(3);
        checks++;
        if (wlog.size() != 1 || wlog[0].addr !== 8'h0C || wlog[0].be !== 4'b1100 || wlog[0].data[31:16] !== 16'hBEEF) begin
            errors++; $display("FAIL hw_write: got %0d writes (first be %b data %h) required 1 write addr 0c be 1100 data[31:16] beef",
                               wlog.size(), (wlog.size() > 0) ? wlog[0].be : 4'h0, (wlog.size() > 0) ? wlog[0].data : 32'h0);
        end
        model_apply();
    endtask

    task automatic test_misaligned();
        n_xf = 1;
        set_xf(0, 1, 32'h41, 3'd2, 32'h12345678, 0);
        run_seq(3);
`ifdef AIRI5C_HASTI_SRAM_ALIGN_CHECK_EN
        checks++;
        if (err_cycles !== 2 || idle_waits !== 1) begin
            errors++; $display("FAIL mis_error: got %0d ERROR cycles %0d wait required 2 and 1", err_cycles, idle_waits);
        end
        checks++;
        if (wlog.size() != 0) begin errors++; $display("FAIL mis_nowrite: got %0d writes required 0", wlog.size()); end
`else
        checks++;
        if (err_cycles !== 0 || idle_waits !== 0) begin
            errors++; $display("FAIL mis_okay: got %0d error cycles %0d waits required 0", err_cycles, idle_waits);
        end
        checks++;
        if (wlog.size() != 1 || wlog[0].addr !== 8'h10 || wlog[0].be !== 4'hF || wlog[0].data !== 32'h12345678) begin
            errors++; $display("FAIL mis_write: got %0d writes required 1 write addr 10 be 1111", wlog.size());
        end
        model_apply();
`endif
    endtask

    task automatic test_reset_discard();
        int we_seen;
        sram_mem[5] = 32'h0BADF00D; ref_mem[5] = 32'h0BADF00D;
        n_xf = 1;
        set_xf(0, 1, 32'h14, 3'd2, 32'h600DF00D, 0);
        run_seq(0);
        nreset = 1'b0;
        #1;
        checks++;
        if ({bus.hready, bus.hresp, sram_en, sram_we, sram_be, sram_addr, sram_wdata, bus.hrdata} !== {1'b1, 79'h0}) begin
            errors++; $display("FAIL rst_mid_outputs: hready=%b hresp=%b en=%b we=%b hrdata=%h required 1 0 0 0 0",
                               bus.hready, bus.hresp, sram_en, sram_we, bus.hrdata);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); nreset = 1'b1;
        we_seen = 0;
        repeat (4) begin @(negedge clk); if (sram_we) we_seen++; end
        @(posedge clk); #1;
        checks++;
        if (we_seen !== 0 || sram_mem[5] !== 32'h0BADF00D) begin
            errors++; $display("FAIL rst_discard: got %0d writes word %h required 0 writes word 0badf00d", we_seen, sram_mem[5]);
        end
        set_xf(0, 0, 32'h14, 3'd2, 32'h0, 0);
        run_seq(2);
        checks++;
        if (obs_rdata[0] !== 32'h0BADF00D) begin
            errors++; $display("FAIL rst_read_old: got %h required 0badf00d", obs_rdata[0]);
        end
    endtask

    task automatic test_random();
        logic [3:0]  be;
        logic [31:0] exp_rd;
        int          exp_w;
        int unsigned off;
        for (int round = 0; round < 3; round++) begin
            n_xf = 40;
            for (int k = 0; k < n_xf; k++) begin
                xf[k].wr   = 1'($urandom_range(0, 1));
                xf[k].size = 3'($urandom_range(0, 2));
                off = (xf[k].size == 3'd0) ? $urandom_range(0, 3) : (xf[k].size == 3'd1) ? 2 * $urandom_range(0, 1) : 0;
                xf[k].addr = 32'($urandom_range(0, 7) * 4 + off);
                xf[k].data = $urandom;
                xf[k].gap  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            end
            run_seq(4);
            checks++;
            if (seq_done !== n_xf) begin errors++; $display("FAIL rnd_done: got %0d required %0d", seq_done, n_xf); end
            for (int k = 0; k < n_xf; k++) begin
                // One wait state exactly when a read directly follows two back-to-back writes
                exp_w = (!xf[k].wr && k >= 2 && xf[k-1].wr && xf[k-2].wr && xf[k].gap == 0 && xf[k-1].gap == 0) ? 1 : 0;
                checks++;
                if (obs_wait[k] !== exp_w) begin
                    errors++; $display("FAIL rnd_wait[%0d.%0d]: got %0d required %0d", round, k, obs_wait[k], exp_w);
                end
                if (xf[k].wr) begin
                    be = exp_be(xf[k].size, xf[k].addr[1:0]);
                    for (int b = 0; b < 4; b++)
                        if (be[b]) ref_mem[xf[k].addr[AW+1:2]][8*b +: 8] = xf[k].data[8*b +: 8];
                end else begin
                    exp_rd = ref_mem[xf[k].addr[AW+1:2]];
                    checks++;
                    if (obs_rdata[k] !== exp_rd) begin
                        errors++; $display("FAIL rnd_rdata[%0d.%0d]: got %h required %h", round, k, obs_rdata[k], exp_rd);
                    end
                end
            end
            checks++;
            if (idle_waits !== 0 || bad_hrdata !== 0 || err_cycles !== 0) begin
                errors++; $display("FAIL rnd_misc: idle waits %0d stray hrdata %0d error cycles %0d required 0",
                                   idle_waits, bad_hrdata, err_cycles);
            end
            for (int w = 0; w < 8; w++) begin
                checks++;
                if (sram_mem[w] !== ref_mem[w]) begin
                    errors++; $display("FAIL rnd_sram[%0d.%0d]: got %h required %h", round, w, sram_mem[w], ref_mem[w]);
                end
            end
        end
    endtask

    initial begin
        rdata_q = '0;
        for (int w = 0; w < NW; w++) begin
            sram_mem[w] = $urandom;
            ref_mem[w]  = sram_mem[w];
        end
        test_reset();
        test_word_write_read();
        test_forward();
        test_back_to_back();
        test_halfword();
        test_misaligned();
        test_reset_discard();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
